// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush and
// data-memory wait freeze, with stall/flush statistics.
module hazard_ctrl #(
   parameter int LU_CYCLES   = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rd,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_timeout,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } st_e;

   localparam int WAIT_W =
      (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam logic [1:0] LU_INIT = 2'(LU_CYCLES - 1);

   st_e               st_q;
   st_e               st_d;
   logic [1:0]        lu_cnt_q;
   logic [1:0]        lu_cnt_d;
   logic [WAIT_W-1:0] wait_q;
   logic              load_use;
   logic              mem_stall;
   logic              run_eval;
   logic              ev_mem;
   logic              ev_br;
   logic              ev_lu;

   assign load_use = idex_memread & (idex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == idex_rd)) |
                      (id_uses_rs2 & (id_rs2 == idex_rd)));
   assign mem_stall = dmem_req & ~dmem_ready;

   assign ev_mem = mem_stall;
   assign ev_br  = branch_taken & ~mem_stall;
   assign ev_lu  = load_use & ~branch_taken & ~mem_stall;

   assign state = st_q;

   always_comb begin
      st_d        = st_q;
      lu_cnt_d    = lu_cnt_q;
      run_eval    = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (!rst) begin
         case (st_q)
            RUN: run_eval = 1'b1;
            LU_STALL: begin
               if (mem_stall) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_write  = 1'b0;
                  exmem_write = 1'b0;
                  st_d        = MEM_WAIT;
                  lu_cnt_d    = 2'd0;
               end else begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  if (lu_cnt_q > 2'd1) begin
                     lu_cnt_d = lu_cnt_q - 2'd1;
                     st_d     = LU_STALL;
                  end else begin
                     lu_cnt_d = 2'd0;
                     st_d     = RUN;
                  end
               end
            end
            MEM_WAIT: begin
               if (!dmem_ready) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_write  = 1'b0;
                  exmem_write = 1'b0;
               end else begin
                  run_eval = 1'b1;
               end
            end
            default: begin
               st_d     = RUN;
               lu_cnt_d = 2'd0;
            end
         endcase

         // Completing memory cycle resolves like a normal RUN cycle
         if (run_eval) begin
            unique case (1'b1)
               ev_mem: begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_write  = 1'b0;
                  exmem_write = 1'b0;
                  st_d        = MEM_WAIT;
               end
               ev_br: begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  st_d        = RUN;
               end
               ev_lu: begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  if (LU_CYCLES > 1) begin
                     st_d     = LU_STALL;
                     lu_cnt_d = LU_INIT;
                  end else begin
                     st_d     = RUN;
                     lu_cnt_d = 2'd0;
                  end
               end
               default: st_d = RUN;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q        <= RUN;
         lu_cnt_q    <= 2'd0;
         wait_q      <= '0;
         mem_timeout <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         st_q     <= st_d;
         lu_cnt_q <= lu_cnt_d;
         if (st_d == MEM_WAIT && st_q != MEM_WAIT) begin
            wait_q <= '0;
         end else if (st_q == MEM_WAIT && wait_q != WAIT_MAX) begin
            wait_q <= wait_q + WAIT_W'(1);
         end
         // Sticky: set on the MEM_TIMEOUT-th consecutive wait cycle
         if (st_q == MEM_WAIT && (int'(wait_q) + 1 >= MEM_TIMEOUT)) begin
            mem_timeout <= 1'b1;
         end
         if (!pc_write && stall_count != '1) begin
            stall_count <= stall_count + CNT_W'(1);
         end
         if (ifid_flush && flush_count != '1) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end

endmodule
